// File: rtl/game_state_ctrl.sv
// Penalty-shootout game sequencer: alternates shooter/keeper attempts, keeps
// saturating round and goal counts, and decides win/lose with sudden death.
module game_state_ctrl #(
    parameter int ROUNDS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       mode_sel,
    input  logic       shot_done,
    input  logic       shot_scored,
    output logic [2:0] game_state,
    output logic       game_mode,
    output logic [3:0] round_counter,
    output logic [7:0] score,
    output logic       is_scored
);

    // state   | meaning
    // START   | idle, game_mode tracks mode_sel, waits for start_btn
    // KEEPER  | opponent shoots, player keeps; closes the round
    // SHOOTER | player shoots
    // WINNER  | player ahead after regulation or sudden death
    // LOOSER  | player behind, or still tied with the round count saturated
    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_KEEPER  = 3'd1,
        ST_SHOOTER = 3'd2,
        ST_WINNER  = 3'd3,
        ST_LOOSER  = 3'd4
    } state_t;

    localparam logic [4:0] ROUNDS_W = ROUNDS[4:0];

    state_t     state;
    logic [3:0] player_goals;
    logic [3:0] opp_goals;

    logic [3:0] player_goals_inc;
    logic [3:0] opp_goals_inc;
    logic [3:0] round_inc;
    logic       regulation_over;
    logic       player_ahead;
    logic       player_behind;
    state_t     round_end_state;

    // Saturating increments; the decision uses post-update counts.
    always_comb begin
        player_goals_inc = player_goals;
        opp_goals_inc    = opp_goals;
        round_inc        = round_counter;
        if (shot_scored && player_goals != 4'hF) player_goals_inc = player_goals + 4'd1;
        if (shot_scored && opp_goals != 4'hF)    opp_goals_inc    = opp_goals + 4'd1;
        if (round_counter != 4'hF)               round_inc        = round_counter + 4'd1;

        regulation_over = ({1'b0, round_inc} >= ROUNDS_W);
        player_ahead    = (player_goals > opp_goals_inc);
        player_behind   = (player_goals < opp_goals_inc);

        round_end_state = ST_SHOOTER;
        if (regulation_over) begin
            if (player_ahead)
                round_end_state = ST_WINNER;
            else if (player_behind)
                round_end_state = ST_LOOSER;
            else if (round_counter == 4'hF)
                // No room left to count another sudden-death round.
                round_end_state = ST_LOOSER;
            else
                round_end_state = ST_SHOOTER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_START;
            game_mode     <= 1'b1;
            round_counter <= 4'd0;
            player_goals  <= 4'd0;
            opp_goals     <= 4'd0;
            is_scored     <= 1'b0;
        end else begin
            case (state)
                ST_START: begin
                    game_mode <= mode_sel;
                    if (start_btn) begin
                        state         <= ST_SHOOTER;
                        round_counter <= 4'd0;
                        player_goals  <= 4'd0;
                        opp_goals     <= 4'd0;
                        is_scored     <= 1'b0;
                    end
                end
                ST_SHOOTER: begin
                    if (shot_done) begin
                        is_scored    <= shot_scored;
                        player_goals <= player_goals_inc;
                        state        <= ST_KEEPER;
                    end
                end
                ST_KEEPER: begin
                    if (shot_done) begin
                        is_scored     <= shot_scored;
                        opp_goals     <= opp_goals_inc;
                        round_counter <= round_inc;
                        state         <= round_end_state;
                    end
                end
                ST_WINNER, ST_LOOSER: begin
                    if (start_btn) state <= ST_START;
                end
                default: begin
                    state         <= ST_START;
                    game_mode     <= 1'b1;
                    round_counter <= 4'd0;
                    player_goals  <= 4'd0;
                    opp_goals     <= 4'd0;
                    is_scored     <= 1'b0;
                end
            endcase
        end
    end

    assign game_state = state;
    assign score      = {player_goals, opp_goals};

endmodule
